// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one cache port among NREQ cores,
// one outstanding access at a time, with a response timeout and sticky error.
module mem_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int ADDRWIDTH = 16,
  parameter int WORDWIDTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*NREQ-1:0]         req_rw,
  input  logic [ADDRWIDTH*NREQ-1:0] req_addr,
  input  logic [WORDWIDTH*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]           rdEn,
  output logic [NREQ-1:0]           wtEn,
  output logic [WORDWIDTH-1:0]      dataFromMem,
  output logic [1:0]                mem_rw,
  output logic [ADDRWIDTH-1:0]      mem_addr,
  output logic [WORDWIDTH-1:0]      mem_wdata,
  input  logic [WORDWIDTH-1:0]      mem_rdata,
  input  logic                      mem_ack,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [IDW-1:0]            err_id
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, nxt;
  logic [1:0]           rw_a   [NREQ];
  logic [ADDRWIDTH-1:0] addr_a [NREQ];
  logic [WORDWIDTH-1:0] wd_a   [NREQ];
  logic [NREQ-1:0]      act;
  logic [IDW-1:0]       rr_ptr, sel, sel_lo, sel_hi;
  logic                 hit, any, tmo;
  logic [1:0]           op;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [WORDWIDTH-1:0] wdata_q;
  logic [TW-1:0]        timer;
  logic [NREQ-1:0]      onehot;
  for (genvar g = 0; g < NREQ; g++) begin : g_sl
    assign rw_a[g]   = req_rw[2*g +: 2];
    assign addr_a[g] = req_addr[ADDRWIDTH*g +: ADDRWIDTH];
    assign wd_a[g]   = req_wdata[WORDWIDTH*g +: WORDWIDTH];
    assign act[g]    = rw_a[g] == 2'd1 || rw_a[g] == 2'd2;
  end
  // lowest active index at or above rr_ptr, else wrap to lowest active overall
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    hit    = 1'b0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (act[j]) sel_lo = IDW'(j);
      if (act[j] && IDW'(j) >= rr_ptr) begin
        sel_hi = IDW'(j);
        hit    = 1'b1;
      end
    end
    sel = hit ? sel_hi : sel_lo;
    any = |act;
  end
  assign tmo = timer == TW'(TIMEOUT-1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = any ? BUSY : IDLE;
      BUSY:    nxt = (mem_ack || tmo) ? RESP : BUSY;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      op          <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      timer       <= '0;
      dataFromMem <= '0;
      timeout_err <= 1'b0;
      err_id      <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          grant_id <= sel;
          op       <= rw_a[sel];
          addr_q   <= addr_a[sel];
          wdata_q  <= wd_a[sel];
        end
        BUSY: begin
          timer <= timer + TW'(1);
          if (mem_ack) begin
            if (op == 2'd1) dataFromMem <= mem_rdata;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            err_id      <= grant_id;
            dataFromMem <= '0;
          end
        end
        RESP: begin
          rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
          timer  <= '0;
        end
        default: ;
      endcase
    end
  end
  assign onehot    = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
  assign rdEn      = (state == RESP && op == 2'd1) ? onehot : '0;
  assign wtEn      = (state == RESP && op == 2'd2) ? onehot : '0;
  assign mem_rw    = (state == BUSY) ? op : 2'd0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = state == BUSY || state == RESP;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed transaction table plus hand sequences for
// timeout, ack-on-boundary, ignored ack and asynchronous reset.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  req_rw = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [3:0]  rdEn, wtEn;
  logic [15:0] dataFromMem, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [1:0]  mem_rw, grant_id, err_id;
  logic        mem_ack = 1'b0;
  logic        busy, timeout_err;
  int total = 0;
  int bad = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(rst_n), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .rdEn(rdEn), .wtEn(wtEn), .dataFromMem(dataFromMem),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rw;
    int          d;
    logic [15:0] rdata;
    logic [1:0]  gnt;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [3:0]  rd;
    logic [3:0]  wt;
    logic [15:0] data;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic set_ports();
    for (int i = 0; i < 4; i++) begin
      req_addr[16*i +: 16]  = 16'h0010 + 16'h0100 * 16'(i);
      req_wdata[16*i +: 16] = 16'hA000 + 16'(i);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // entered 1 time unit after an edge with the DUT idle; ack arrives on BUSY cycle d+1
  task automatic run_txn(input vec_t v);
    set_ports();
    req_rw  = v.rw;
    mem_ack = 1'b0;
    step();
    chk("busy_on", 32'(busy), 32'd1);
    chk("grant", 32'(grant_id), 32'(v.gnt));
    chk("mem_rw", 32'(mem_rw), 32'(v.op));
    chk("mem_addr", 32'(mem_addr), 32'(v.addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(v.wd));
    for (int c = 0; c < v.d; c++) begin
      req_addr = '1;
      step();
      chk("hold_rw", 32'(mem_rw), 32'(v.op));
      chk("hold_addr", 32'(mem_addr), 32'(v.addr));
    end
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    req_rw    = '0;
    chk("rdEn", 32'(rdEn), 32'(v.rd));
    chk("wtEn", 32'(wtEn), 32'(v.wt));
    chk("data", 32'(dataFromMem), 32'(v.data));
    chk("resp_rw", 32'(mem_rw), 32'd0);
    step();
    chk("busy_off", 32'(busy), 32'd0);
    chk("en_off", 32'({rdEn, wtEn}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    tv[0]  = '{8'hAA, 0,  16'h1234, 2'd0, 2'd2, 16'h0010, 16'hA000, 4'h0, 4'h1, 16'h0000};
    tv[1]  = '{8'hAA, 0,  16'h1234, 2'd1, 2'd2, 16'h0110, 16'hA001, 4'h0, 4'h2, 16'h0000};
    tv[2]  = '{8'hAA, 0,  16'h1234, 2'd2, 2'd2, 16'h0210, 16'hA002, 4'h0, 4'h4, 16'h0000};
    tv[3]  = '{8'hAA, 0,  16'h1234, 2'd3, 2'd2, 16'h0310, 16'hA003, 4'h0, 4'h8, 16'h0000};
    tv[4]  = '{8'hAA, 0,  16'h1234, 2'd0, 2'd2, 16'h0010, 16'hA000, 4'h0, 4'h1, 16'h0000};
    tv[5]  = '{8'h01, 1,  16'hBEEF, 2'd0, 2'd1, 16'h0010, 16'hA000, 4'h1, 4'h0, 16'hBEEF};
    tv[6]  = '{8'h43, 2,  16'h5A5A, 2'd3, 2'd1, 16'h0310, 16'hA003, 4'h8, 4'h0, 16'h5A5A};
    tv[7]  = '{8'h0B, 0,  16'h1111, 2'd1, 2'd2, 16'h0110, 16'hA001, 4'h0, 4'h2, 16'h5A5A};
    tv[8]  = '{8'h55, 3,  16'h0F0F, 2'd2, 2'd1, 16'h0210, 16'hA002, 4'h4, 4'h0, 16'h0F0F};
    tv[9]  = '{8'h11, 0,  16'h7777, 2'd0, 2'd1, 16'h0010, 16'hA000, 4'h1, 4'h0, 16'h7777};
    tv[10] = '{8'h11, 0,  16'h8888, 2'd2, 2'd1, 16'h0210, 16'hA002, 4'h4, 4'h0, 16'h8888};
    tv[11] = '{8'h04, 63, 16'hCAFE, 2'd1, 2'd1, 16'h0110, 16'hA001, 4'h2, 4'h0, 16'hCAFE};
    set_ports();
    #1;
    chk("rst_outs", 32'({mem_rw, rdEn, wtEn, grant_id, busy, timeout_err, err_id}), 32'd0);
    chk("rst_data", 32'(dataFromMem), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 12; k++) run_txn(tv[k]);
    chk("boundary_err", 32'(timeout_err), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    step();
    step();
    chk("stray_ack_busy", 32'(busy), 32'd0);
    chk("stray_ack_data", 32'(dataFromMem), 32'hCAFE);
    chk("stray_ack_en", 32'({rdEn, wtEn}), 32'd0);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    req_rw = 8'h10;
    step();
    chk("to_grant", 32'(grant_id), 32'd2);
    repeat (63) step();
    chk("to_last_busy", 32'({busy, mem_rw}), 32'({1'b1, 2'd1}));
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    step();
    req_rw = '0;
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_err_id", 32'(err_id), 32'd2);
    chk("to_rdEn", 32'(rdEn), 32'h4);
    chk("to_data", 32'(dataFromMem), 32'd0);
    chk("to_rw", 32'(mem_rw), 32'd0);
    step();
    chk("to_idle", 32'(busy), 32'd0);
    run_txn('{8'h08, 0, 16'h3333, 2'd1, 2'd2, 16'h0110, 16'hA001, 4'h0, 4'h2, 16'h0000});
    chk("to_sticky", 32'(timeout_err), 32'd1);
    req_rw = 8'h40;
    step();
    chk("ar_grant", 32'(grant_id), 32'd3);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rw", 32'(mem_rw), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_err", 32'({timeout_err, err_id, grant_id}), 32'd0);
    step();
    chk("ar_no_en", 32'({rdEn, wtEn}), 32'd0);
    rst_n = 1'b1;
    run_txn('{8'h55, 0, 16'h1111, 2'd0, 2'd1, 16'h0010, 16'hA000, 4'h1, 4'h0, 16'h1111});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
